// File: rtl/note_seq_pkg.sv
// Shared types for the note sequencer: FSM state encoding and note word field layout.
package note_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT,
        DECODE,
        NOTE,
        GAP,
        PAUSED,
        END,
        DONE
    } state_t;

    localparam int DUR_MSB = 23;
    localparam int DUR_LSB = 16;
    localparam int DIV_MSB = 15;
    localparam int DIV_LSB = 0;

    localparam logic [7:0] END_MARKER_DUR = 8'd0;

endpackage

// File: rtl/note_sequencer_tick_prescaler.sv
// tick_prescaler: free-running divider producing a 1-cycle tick every PRESCALE enabled cycles.
// The count is held (not cleared) while enable is low, so a paused note resumes mid-tick.
module tick_prescaler #(
    parameter int PRESCALE = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: walks the note ROM and drives the tone generator divisor/enable under play/pause/stop.
// Define PLAYER_LOOP_EN to wrap back to address 0 at end of song instead of stopping in DONE.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int CLK_FREQ    = 50000000,
    parameter int TICK_MS     = 10,
    parameter int GAP_TICKS   = 1,
    parameter int MEMORY_SIZE = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           play,
    input  logic                           pause,
    input  logic                           stop,
    output logic [$clog2(MEMORY_SIZE)-1:0] mem_addr,
    input  logic [23:0]                    mem_rdata,
    output logic [15:0]                    tone_div,
    output logic                           tone_en,
    output logic                           playing,
    output logic                           done
);

    localparam int ADDR_W   = $clog2(MEMORY_SIZE);
    localparam int PRESCALE = CLK_FREQ / 1000 * TICK_MS;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEMORY_SIZE - 1);
    localparam logic [7:0] GAP_LIM = (GAP_TICKS > 255) ? 8'd255 : 8'(GAP_TICKS);

    state_t            r_state, r_ret_state;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_tone_div;
    logic              r_tone_en, r_ret_tone_en;
    logic [7:0]        r_remaining;

    state_t            w_state, w_ret_state;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [15:0]       w_tone_div;
    logic              w_tone_en, w_ret_tone_en;
    logic [7:0]        w_remaining;
    logic              w_active, w_tick, w_pres_clear, w_pres_en;

    wire [7:0]  w_dur      = mem_rdata[DUR_MSB:DUR_LSB];
    wire [15:0] w_note_div = mem_rdata[DIV_MSB:DIV_LSB];
    wire [7:0]  w_rem_dec  = (r_remaining != 8'd0) ? r_remaining - 8'd1 : 8'd0;

    assign w_active  = r_state inside {FETCH, WAIT, DECODE, NOTE, GAP};
    assign w_pres_en = (r_state inside {NOTE, GAP}) && !pause && !stop;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (w_pres_clear),
        .enable(w_pres_en),
        .tick  (w_tick)
    );

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_state       = r_state;
        w_ret_state   = r_ret_state;
        w_mem_addr    = r_mem_addr;
        w_tone_div    = r_tone_div;
        w_tone_en     = r_tone_en;
        w_ret_tone_en = r_ret_tone_en;
        w_remaining   = r_remaining;
        w_pres_clear  = 1'b0;

        if (stop) begin
            w_state      = IDLE;
            w_mem_addr   = '0;
            w_tone_div   = '0;
            w_tone_en    = 1'b0;
            w_remaining  = '0;
            w_pres_clear = 1'b1;
        end else if (pause && w_active) begin
            // A read still in flight is simply re-issued after resume.
            w_state       = PAUSED;
            w_ret_state   = (r_state == WAIT) ? FETCH : r_state;
            w_ret_tone_en = r_tone_en;
            w_tone_en     = 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (play) begin
                        w_state    = FETCH;
                        w_mem_addr = '0;
                    end
                end
                PAUSED: begin
                    if (play) begin
                        w_state   = r_ret_state;
                        w_tone_en = r_ret_tone_en;
                    end
                end
                FETCH: w_state = WAIT;
                WAIT:  w_state = DECODE;
                DECODE: begin
                    w_pres_clear = 1'b1;
                    if (w_dur == END_MARKER_DUR) begin
                        w_state = END;
                    end else begin
                        w_tone_div  = w_note_div;
                        w_remaining = w_dur;
                        if (w_dur <= GAP_LIM) begin
                            w_state   = GAP;
                            w_tone_en = 1'b0;
                        end else begin
                            w_state   = NOTE;
                            w_tone_en = (w_note_div != 16'd0);
                        end
                    end
                end
                NOTE, GAP: begin
                    if (w_tick) begin
                        w_remaining = w_rem_dec;
                        if (w_rem_dec == 8'd0) begin
                            w_tone_en = 1'b0;
                            if (r_mem_addr == LAST_ADDR) begin
                                w_state = END;
                            end else begin
                                w_state    = FETCH;
                                w_mem_addr = r_mem_addr + 1'b1;
                            end
                        end else if (w_rem_dec <= GAP_LIM) begin
                            w_state   = GAP;
                            w_tone_en = 1'b0;
                        end
                    end
                end
                END: begin
`ifdef PLAYER_LOOP_EN
                    w_state    = FETCH;
                    w_mem_addr = '0;
`else
                    w_state    = DONE;
                    w_tone_div = '0;
                    w_tone_en  = 1'b0;
`endif
                end
                default: w_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ret_state   <= IDLE;
            r_mem_addr    <= '0;
            r_tone_div    <= '0;
            r_tone_en     <= 1'b0;
            r_ret_tone_en <= 1'b0;
            r_remaining   <= '0;
        end else begin
            r_state       <= w_state;
            r_ret_state   <= w_ret_state;
            r_mem_addr    <= w_mem_addr;
            r_tone_div    <= w_tone_div;
            r_tone_en     <= w_tone_en;
            r_ret_tone_en <= w_ret_tone_en;
            r_remaining   <= w_remaining;
        end
    end

    assign mem_addr = r_mem_addr;
    assign tone_div = r_tone_div;
    assign tone_en  = r_tone_en;
    assign done     = (r_state == END);
`ifdef PLAYER_LOOP_EN
    assign playing  = w_active || (r_state == END);
`else
    assign playing  = w_active;
`endif

endmodule
